// File: rtl/adder_step_controller.sv
// Step sequencer around an external 4-bit adder: debounced button loads A, then B/cin, then latches {cout,sum}.
// Result registers one edge after the ADD cycle; no backpressure, presses outside LOAD_A/LOAD_B/SHOW are dropped.
module adder_step_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       cin_sw,
    input  logic       btn,
    input  logic       acc_mode,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    output logic       add_ci,
    input  logic [3:0] add_s,
    input  logic       add_cout,
    output logic [4:0] result,
    output logic       result_valid,
    output logic [1:0] state_o,
    output logic       overflow_sticky
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        ADD    = 2'd2,
        SHOW   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             btn_s;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             press;

    state_t     state;
    logic [3:0] a_reg;
    logic [3:0] b_reg;
    logic       ci_reg;

    // Debounce: a change must persist DEBOUNCE_CYCLES cycles; press fires with the 0->1 acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            btn_s  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= btn;
            btn_s <= sync1;
            press <= 1'b0;
            if (btn_s == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= btn_s;
                cnt    <= '0;
                press  <= btn_s;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= LOAD_A;
            a_reg           <= 4'd0;
            b_reg           <= 4'd0;
            ci_reg          <= 1'b0;
            result          <= 5'd0;
            result_valid    <= 1'b0;
            overflow_sticky <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (press) begin
                        a_reg <= sw;
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (press) begin
                        b_reg  <= sw;
                        ci_reg <= cin_sw;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    result          <= {add_cout, add_s};
                    result_valid    <= 1'b1;
                    overflow_sticky <= overflow_sticky | add_cout;
                    state           <= SHOW;
                end
                SHOW: begin
                    if (press) begin
                        if (acc_mode) begin
                            // Feedback wraps modulo 16; the lost carry already sits in overflow_sticky.
                            a_reg <= result[3:0];
                            state <= LOAD_B;
                        end else begin
                            result_valid    <= 1'b0;
                            overflow_sticky <= 1'b0;
                            state           <= LOAD_A;
                        end
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

    assign add_a   = a_reg;
    assign add_b   = b_reg;
    assign add_ci  = ci_reg;
    assign state_o = state;

endmodule

// File: tb/tb_adder_step_controller.sv
// Directed bench for adder_step_controller with a behavioural 4-bit adder on the downstream side.
module tb_adder_step_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic       cin_sw;
    logic       btn;
    logic       acc_mode;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_ci;
    logic [3:0] add_s;
    logic       add_cout;
    logic [4:0] result;
    logic       result_valid;
    logic [1:0] state_o;
    logic       overflow_sticky;

    int total = 0;
    int bad = 0;
    int add_cycles = 0;

    adder_step_controller #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw(sw),
        .cin_sw(cin_sw),
        .btn(btn),
        .acc_mode(acc_mode),
        .add_a(add_a),
        .add_b(add_b),
        .add_ci(add_ci),
        .add_s(add_s),
        .add_cout(add_cout),
        .result(result),
        .result_valid(result_valid),
        .state_o(state_o),
        .overflow_sticky(overflow_sticky)
    );

    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_ci};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Clean press: hold 10 cycles, release 10 cycles; counts cycles observed in ADD.
    task automatic press_btn(input logic [3:0] v, input logic c);
        sw = v;
        cin_sw = c;
        btn = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (state_o == 2'd2) add_cycles++;
        end
        btn = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (state_o == 2'd2) add_cycles++;
        end
    endtask

    task automatic apply_reset();
        btn = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        btn = 1'b1;
        sw = 4'd3;
        cin_sw = 1'b0;
        acc_mode = 1'b0;

        // 1. reset with button held
        repeat (2) @(negedge clk);
        chk("rst_state", state_o, 0);
        chk("rst_result", result, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_sticky", overflow_sticky, 0);
        chk("rst_ops", {add_a, add_b, add_ci}, 0);
        rst_n = 1'b1;
        n = 0;
        while (state_o != 2'd1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_press_latency", n, 7);
        chk("rst_press_a", add_a, 3);
        btn = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_single_press", state_o, 1);

        // 2. debounce
        apply_reset();
        sw = 4'd5;
        btn = 1'b1;
        repeat (2) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch_no_press", state_o, 0);
        btn = 1'b1;
        repeat (10) @(negedge clk);
        chk("held_press_state", state_o, 1);
        chk("held_press_a", add_a, 5);
        btn = 1'b0;
        @(negedge clk);
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
        repeat (15) @(negedge clk);
        chk("release_bounce_state", state_o, 1);

        // 3. plain add 5 + 9
        add_cycles = 0;
        press_btn(4'd9, 1'b0);
        chk("add_one_cycle", add_cycles, 1);
        chk("plain_state", state_o, 3);
        chk("plain_b", add_b, 9);
        chk("plain_result", result, 14);
        chk("plain_valid", result_valid, 1);
        chk("plain_sticky", overflow_sticky, 0);
        press_btn(4'd0, 1'b0);
        chk("plain_clear_state", state_o, 0);

        // 4. carry 15 + 1 + 1
        press_btn(4'd15, 1'b0);
        press_btn(4'd1, 1'b1);
        chk("carry_result", result, 17);
        chk("carry_sticky", overflow_sticky, 1);
        press_btn(4'd0, 1'b0);
        chk("carry_clr_state", state_o, 0);
        chk("carry_clr_valid", result_valid, 0);
        chk("carry_clr_sticky", overflow_sticky, 0);

        // 5. accumulate 7 + 5, then 12 + 6
        acc_mode = 1'b1;
        press_btn(4'd7, 1'b0);
        press_btn(4'd5, 1'b0);
        chk("acc1_result", result, 12);
        chk("acc1_sticky", overflow_sticky, 0);
        press_btn(4'd0, 1'b0);
        chk("acc1_a", add_a, 12);
        chk("acc1_state", state_o, 1);
        chk("acc1_valid_kept", result_valid, 1);
        press_btn(4'd6, 1'b0);
        chk("acc2_result", result, 18);
        chk("acc2_sticky", overflow_sticky, 1);
        press_btn(4'd0, 1'b0);
        chk("acc2_a_wrap", add_a, 2);
        chk("acc2_state", state_o, 1);
        acc_mode = 1'b0;

        // 6. reset while in LOAD_B
        apply_reset();
        press_btn(4'd9, 1'b0);
        chk("midrst_pre_a", add_a, 9);
        chk("midrst_pre_state", state_o, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_a", add_a, 0);
        chk("midrst_state", state_o, 0);
        rst_n = 1'b1;
        add_cycles = 0;
        repeat (20) begin
            @(negedge clk);
            if (state_o == 2'd2) add_cycles++;
        end
        chk("midrst_no_add", add_cycles, 0);
        chk("midrst_valid", result_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_step_controller.md
Name: adder_step_controller

Overview:
- Sequencing stage wrapped around the 4-bit ripple-carry adder on the lab board.
- Upstream side: debounces the step button, captures operands A and B and carry-in from the slide switches, and drives them registered into the adder.
- Downstream side: latches the adder's sum and carry-out into a held 5-bit result for LEDs/7-seg.
- Supports an accumulate mode in which the previous sum becomes the next A operand.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles the synchronized button must differ from its stable value before the change is accepted (board build overrides to 500000).
- CNT_W, 20, width of the debounce counter; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- sw  input  4  operand switches
- cin_sw  input  1  carry-in switch
- btn  input  1  raw step pushbutton, asynchronous to clk, active-high
- acc_mode  input  1  1 = accumulate (sum feeds back as A)
- add_a  output  4  operand A to adder
- add_b  output  4  operand B to adder
- add_ci  output  1  carry-in to adder
- add_s  input  4  adder sum (combinational from add_a/add_b/add_ci)
- add_cout  input  1  adder carry-out
- result  output  5  {cout, sum} latched
- result_valid  output  1  result holds a completed addition
- state_o  output  2  current FSM state for LEDs
- overflow_sticky  output  1  a carry-out of 1 has been seen since last clear

Behaviour:
- Reset (rst_n=0 at a rising edge): sync flops, stable, counter, press=0; a_reg=b_reg=0, ci_reg=0; result=0, result_valid=0, overflow_sticky=0; state=LOAD_A (state_o=0). Reset takes priority over all events, including a press in the same cycle.
- Button path: 2-flop synchronizer to btn_s.
  - cnt clears whenever btn_s==stable.
  - Otherwise cnt increments. When btn_s!=stable and cnt==DEBOUNCE_CYCLES-1: stable<=btn_s, cnt<=0.
  - press: registered one-cycle pulse, set on the edge where stable goes 0->1.
  - btn held from edge 1 onward: press is high in the cycle after edge DEBOUNCE_CYCLES+2.
  - Glitches shorter than DEBOUNCE_CYCLES cycles produce no press. Release produces no press.
- add_a=a_reg, add_b=b_reg, add_ci=ci_reg, driven directly from registers.
- FSM (state_o encoding):
  - LOAD_A (0): on press: a_reg<=sw; go LOAD_B.
  - LOAD_B (1): on press: b_reg<=sw, ci_reg<=cin_sw; go ADD.
  - ADD (2): exactly one cycle, no press needed. result<={add_cout, add_s}, result_valid<=1, overflow_sticky<=overflow_sticky|add_cout; go SHOW. A press arriving in ADD is ignored.
  - SHOW (3): result held. On press:
    - If acc_mode=1: a_reg<=result[3:0]; go LOAD_B; result_valid stays 1.
    - If acc_mode=0: result_valid<=0, overflow_sticky<=0; go LOAD_A.
- acc_mode is sampled only on the SHOW press; changing it elsewhere has no effect.
- Arithmetic is performed only by the external adder. Sum width is 5 bits (max 15+15+1=31 -> 1_1111). The accumulate feedback drops bit 4: wrap modulo 16, with the carry recorded in overflow_sticky.
- Result latency: ADD is the cycle after the LOAD_B press cycle. result/result_valid update one edge later. Operands are stable one full cycle before sampling.
- Reset mid-operation: returns to LOAD_A with all registers cleared on that edge. A button held through reset yields one press DEBOUNCE_CYCLES+2 edges after reset release (stable restarts from 0).

Test Plan:
1. Reset: rst_n=0 for 2 cycles with btn=1 -> state_o=0, result=0, result_valid=0, overflow_sticky=0, add_a/add_b/add_ci=0; after release with btn still 1 -> one press at edge DEBOUNCE_CYCLES+2.
2. Debounce: btn high for 2 cycles (D=4) -> no state change; btn held 10 cycles -> exactly one press, state LOAD_A->LOAD_B; bounce 1-0-1 on release -> no extra press.
3. Plain add: sw=5 press, sw=9 cin_sw=0 press -> state ADD then SHOW, result=5'b01110 (14), result_valid=1, overflow_sticky=0.
4. Carry: A=15, B=1, cin_sw=1 -> result=5'b10001 (17), overflow_sticky=1; press in SHOW with acc_mode=0 -> LOAD_A, result_valid=0, overflow_sticky=0.
5. Accumulate: acc_mode=1, A=7, B=5, ci=0 -> 12; press -> add_a=12, LOAD_B; B=6 -> result=5'b10010 (18), overflow_sticky=1; press -> add_a=2.
6. Reset in LOAD_B after A=9 loaded -> next edge add_a=0, state_o=0, and no ADD occurs.
